sent_apb_master: RTL and testbench

APB requester that drives the register ports of the SENT transmitter and receiver tops (`PADDR`/`PWDATA`/`PWRITE`/`PSELx`/`PENABLE` out, `PRDATA`/`PREADY` in). It takes single read/write commands from a simple valid/ready command port and runs one APB setup + access transfer per command. It returns one response per command. It is the initiator side for the existing APB slaves and sits between the test/host logic and `sent_tx_top`/`sent_rx_top`.

---
 rtl/sent_apb_master_if.sv | 45 ++++
 rtl/sent_apb_master.sv | 134 +++++++++++++
 tb/tb_sent_apb_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sent_apb_master_if.sv
// Command/response port and APB requester bus of sent_apb_master.
// The master modport is the requester's view; the slave modport is the
// view of whoever supplies commands and plays the APB completer.
//
// Handshake rules:
//   Command: a command transfers on a rising PCLK edge where cmd_valid_i
//   and cmd_ready_o are both 1.
//   Response: rsp_valid_o is a one-cycle strobe and cannot be stalled.
//   APB: PSELx_o=1/PENABLE_o=0 is SETUP. PSELx_o=1/PENABLE_o=1 is ACCESS.
//   ACCESS completes on the edge where PREADY_i=1.
// fsm_state exposes the requester state for debug and checkers:
//   0 = IDLE, 1 = SETUP, 2 = ACCESS, 3 = RESP.
interface sent_apb_master_if #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_write_i;
  logic [ADDRESSWIDTH-1:0] cmd_addr_i;
  logic [DATAWIDTH-1:0]    cmd_wdata_i;
  logic                    rsp_valid_o;
  logic [DATAWIDTH-1:0]    rsp_rdata_o;
  logic                    rsp_err_o;
  logic [ADDRESSWIDTH-1:0] PADDR_o;
  logic [DATAWIDTH-1:0]    PWDATA_o;
  logic                    PWRITE_o;
  logic                    PSELx_o;
  logic                    PENABLE_o;
  logic [DATAWIDTH-1:0]    PRDATA_i;
  logic                    PREADY_i;
  logic [1:0]              fsm_state;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, PRDATA_i, PREADY_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, fsm_state
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, PRDATA_i, PREADY_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o, fsm_state
  );
endinterface

// File: rtl/sent_apb_master.sv
// sent_apb_master: single-command APB requester for the SENT tx/rx register
// ports. Each accepted command runs one SETUP + ACCESS transfer and ends
// with a one-cycle response strobe. All outputs are registered.
// Optional feature: define SENT_APB_MASTER_TIMEOUT_EN to abort an ACCESS
// phase after TIMEOUT consecutive cycles with PREADY_i low. The response
// then has rsp_err_o=1 and rsp_rdata_o=0.
module sent_apb_master #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16,
  parameter int TIMEOUT      = 15
) (
  input logic               PCLK,
  input logic               PRESET,
  sent_apb_master_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("sent_apb_master: TIMEOUT must be at least 1");
  end

  logic [1:0]              state;
  logic                    cmd_ready_q;
  logic                    rsp_valid_q;
  logic [DATAWIDTH-1:0]    rsp_rdata_q;
  logic                    rsp_err_q;
  logic [ADDRESSWIDTH-1:0] paddr_q;
  logic [DATAWIDTH-1:0]    pwdata_q;
  logic                    pwrite_q;
  logic                    psel_q;
  logic                    penable_q;

`ifdef SENT_APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  // Transfer sequencer: state, APB drive registers and the response registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= S_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
`ifdef SENT_APB_MASTER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid_i && cmd_ready_q) begin
            // The command fields are held on the APB bus until the next handshake.
            paddr_q     <= bus.cmd_addr_i;
            pwdata_q    <= bus.cmd_wdata_i;
            pwrite_q    <= bus.cmd_write_i;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            state       <= S_SETUP;
          end else begin
            // This also raises ready one cycle after reset is released.
            cmd_ready_q <= 1'b1;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state     <= S_ACCESS;
`ifdef SENT_APB_MASTER_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end
        S_ACCESS: begin
          if (bus.PREADY_i) begin
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= S_RESP;
          end
`ifdef SENT_APB_MASTER_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th low sample, so the transfer is abandoned.
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
`ifdef SENT_APB_MASTER_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif
  assign bus.PADDR_o     = paddr_q;
  assign bus.PWDATA_o    = pwdata_q;
  assign bus.PWRITE_o    = pwrite_q;
  assign bus.PSELx_o     = psel_q;
  assign bus.PENABLE_o   = penable_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_sent_apb_master.sv
// Testbench for sent_apb_master. The bench plays both the command source and
// the APB completer. A register array (mem) is the reference for read data.
// The cycle-by-cycle transfer shape is derived from the command's wait count.
module tb_sent_apb_master;

  localparam int TMO = 4;

  logic pclk;
  logic preset;
  int   cyc;
  int   n_checks;
  int   n_errors;

  logic [15:0] mem [8];
  logic [15:0] exp_q [$];

  sent_apb_master_if #(.ADDRESSWIDTH(3), .DATAWIDTH(16)) ifc ();

  sent_apb_master #(
    .ADDRESSWIDTH(3),
    .DATAWIDTH(16),
    .TIMEOUT(TMO)
  ) dut (
    .PCLK(pclk),
    .PRESET(preset),
    .bus(ifc)
  );

  // Clock and cycle counter
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Runs one command from the handshake through one cycle past the response.
  // waits is the number of PREADY_i-low ACCESS cycles the completer inserts.
  task automatic do_cmd(input logic wr, input logic [2:0] a, input logic [15:0] wd, input int waits);
    int t;
    int n_acc;
    logic to;
    logic [15:0] exp_rd;
    logic [15:0] got_exp;
    to = 1'b0;
    n_acc = waits + 1;
`ifdef SENT_APB_MASTER_TIMEOUT_EN
    if (waits >= TMO) begin
      to = 1'b1;
      n_acc = TMO;
    end
`endif
    exp_rd = (wr || to) ? 16'h0 : mem[a];
    exp_q.push_back(exp_rd);
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_write_i = wr;
    ifc.cmd_addr_i  = a;
    ifc.cmd_wdata_i = wd;
    t = 0;
    while (!ifc.cmd_ready_o && t < 20) begin
      @(negedge pclk);
      t++;
    end
    chk("hs_ready", ifc.cmd_ready_o, 1);
    // SETUP cycle. Command inputs are now ignored, so they are scrambled.
    @(negedge pclk);
    ifc.cmd_valid_i = 1'($urandom);
    ifc.cmd_write_i = 1'($urandom);
    ifc.cmd_addr_i  = 3'($urandom);
    ifc.cmd_wdata_i = 16'($urandom);
    chk("setup_sel", {ifc.PSELx_o, ifc.PENABLE_o}, 2'b10);
    chk("setup_bus", {ifc.PWRITE_o, ifc.PADDR_o, ifc.PWDATA_o}, {wr, a, wd});
    chk("setup_rsp", {ifc.rsp_valid_o, ifc.cmd_ready_o}, 2'b00);
    ifc.PREADY_i = 1'($urandom);
    ifc.PRDATA_i = 16'($urandom);
    for (int i = 0; i < n_acc; i++) begin
      @(negedge pclk);
      chk("acc_sel", {ifc.PSELx_o, ifc.PENABLE_o}, 2'b11);
      chk("acc_bus", {ifc.PWRITE_o, ifc.PADDR_o, ifc.PWDATA_o}, {wr, a, wd});
      chk("acc_rsp", ifc.rsp_valid_o, 0);
      ifc.PREADY_i = (!to && i == waits);
      ifc.PRDATA_i = (!to && i == waits) ? mem[a] : 16'($urandom);
    end
    // RESP cycle
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b0;
    ifc.PREADY_i = 1'($urandom);
    ifc.PRDATA_i = 16'($urandom);
    got_exp = exp_q.pop_front();
    chk("resp_valid", ifc.rsp_valid_o, 1);
    chk("resp_sel", {ifc.PSELx_o, ifc.PENABLE_o}, 2'b00);
    chk("resp_rdata", ifc.rsp_rdata_o, got_exp);
    chk("resp_err", ifc.rsp_err_o, to);
    if (wr && !to) mem[a] = wd;
    @(negedge pclk);
    chk("post_valid", ifc.rsp_valid_o, 0);
    chk("post_hold", {ifc.rsp_err_o, ifc.rsp_rdata_o}, {to, got_exp});
    chk("post_bus", {ifc.PWRITE_o, ifc.PADDR_o, ifc.PWDATA_o}, {wr, a, wd});
    chk("post_ready", ifc.cmd_ready_o, 1);
  endtask

  initial begin
    int hs_n;
    int rsp_n;
    int bad;
    int hs_cyc [3];
    logic drop;
    logic [15:0] bw [3];
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    preset = 1'b1;
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_write_i = 1'b1;
    ifc.cmd_addr_i  = 3'd7;
    ifc.cmd_wdata_i = 16'hFFFF;
    ifc.PREADY_i    = 1'b1;
    ifc.PRDATA_i    = 16'hFFFF;

    // Reset held for 3 cycles with a command offered
    repeat (3) begin
      @(negedge pclk);
      chk("rst_ctl", {ifc.cmd_ready_o, ifc.rsp_valid_o, ifc.rsp_err_o,
                      ifc.PWRITE_o, ifc.PSELx_o, ifc.PENABLE_o}, 0);
      chk("rst_data", {ifc.rsp_rdata_o, ifc.PWDATA_o, ifc.PADDR_o}, 0);
    end
    preset = 1'b0;
    ifc.cmd_valid_i = 1'b0;
    chk("rel_ready0", ifc.cmd_ready_o, 0);
    @(negedge pclk);
    chk("rel_ready1", ifc.cmd_ready_o, 1);

    // Directed: write 0x5A5A to address 3 with no waits, then the read of address 5 with two waits
    do_cmd(1'b1, 3'd3, 16'h5A5A, 0);
    mem[5] = 16'h1234;
    do_cmd(1'b0, 3'd5, 16'h0000, 2);
    do_cmd(1'b0, 3'd3, 16'h0000, 1);

    // Back-to-back: cmd_valid_i held high for three writes with PREADY_i=1
    for (int k = 0; k < 3; k++) bw[k] = 16'($urandom);
    hs_n = 0;
    rsp_n = 0;
    drop = 1'b0;
    ifc.PREADY_i = 1'b1;
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_write_i = 1'b1;
    ifc.cmd_addr_i  = 3'd0;
    ifc.cmd_wdata_i = bw[0];
    for (int n = 0; n < 16; n++) begin
      if (drop) begin
        drop = 1'b0;
        if (hs_n < 3) begin
          ifc.cmd_addr_i  = 3'(hs_n);
          ifc.cmd_wdata_i = bw[hs_n];
        end else begin
          ifc.cmd_valid_i = 1'b0;
        end
      end
      if (ifc.rsp_valid_o) rsp_n++;
      if (ifc.cmd_valid_i && ifc.cmd_ready_o) begin
        if (hs_n < 3) hs_cyc[hs_n] = cyc;
        mem[3'(hs_n)] = ifc.cmd_wdata_i;
        hs_n++;
        drop = 1'b1;
      end
      @(negedge pclk);
    end
    chk("b2b_hs_count", hs_n, 3);
    chk("b2b_rsp_count", rsp_n, 3);
    chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 4);
    chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 4);
    for (int k = 0; k < 3; k++) do_cmd(1'b0, 3'(k), 16'h0, 0);

`ifdef SENT_APB_MASTER_TIMEOUT_EN
    // Timeout: PREADY_i never rises, then PREADY_i rises on the last allowed sample
    do_cmd(1'b0, 3'd6, 16'h0, TMO + 2);
    do_cmd(1'b1, 3'd6, 16'hBEEF, TMO);
    do_cmd(1'b0, 3'd6, 16'h0, TMO - 1);
`else
    // With no timeout, ACCESS waits indefinitely
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_write_i = 1'b0;
    ifc.cmd_addr_i  = 3'd6;
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b0;
    ifc.PREADY_i = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (!(ifc.PSELx_o && ifc.PENABLE_o && !ifc.rsp_valid_o)) bad++;
    end
    chk("stall_100", bad, 0);
    ifc.PREADY_i = 1'b1;
    ifc.PRDATA_i = mem[6];
    @(negedge pclk);
    chk("stall_resp", {ifc.rsp_valid_o, ifc.rsp_err_o, ifc.rsp_rdata_o}, {2'b10, mem[6]});
    @(negedge pclk);
`endif

    // Randomized commands with random wait states
    for (int r = 0; r < 25; r++)
      do_cmd(1'($urandom), 3'($urandom), 16'($urandom), $urandom_range(0, 6));

    // Reset during ACCESS: the bus drops and no response appears
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_write_i = 1'b0;
    ifc.cmd_addr_i  = 3'd2;
    @(negedge pclk);
    ifc.cmd_valid_i = 1'b0;
    ifc.PREADY_i = 1'b0;
    @(negedge pclk);
    chk("mid_acc", {ifc.PSELx_o, ifc.PENABLE_o}, 2'b11);
    preset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_sel", {ifc.PSELx_o, ifc.PENABLE_o, ifc.rsp_valid_o}, 3'b000);
    preset = 1'b0;
    ifc.PREADY_i = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge pclk);
      if (ifc.rsp_valid_o || ifc.PSELx_o) bad++;
    end
    chk("mid_no_rsp", bad, 0);
    do_cmd(1'b0, 3'd2, 16'h0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
